// File: rtl/game_flow_controller.sv
// game_flow_controller: game phase sequencer and per-frame physics update handshake.
// Optional build macro GFC_OVERRUN_CNT_EN adds a saturating dropped-frame counter
// on OVERRUN_COUNT; without it OVERRUN_COUNT is constant 0.
module game_flow_controller #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned DELAY_FRAMES = 60
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FRAME_RENDERED,
  input  logic        BTN_RELEASE,
  input  logic        SW_PAUSE,
  input  logic        PHYS_DONE,
  input  logic        BALL_LOST,
  input  logic [71:0] BLOCK_STATE,
  output logic        START_UPDATE,
  output logic        HOLD_BALL,
  output logic        LOAD_LEVEL,
  output logic [2:0]  LIVES,
  output logic [2:0]  GAME_STATE,
  output logic [7:0]  OVERRUN_COUNT
);

  typedef enum logic [2:0] {
    ATTRACT  = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    LOST     = 3'd3,
    CLEARED  = 3'd4,
    GAMEOVER = 3'd5
  } state_t;

  localparam logic [2:0] LIVES_INIT_L = 3'(LIVES_INIT);
  localparam logic [7:0] DELAY_L      = 8'(DELAY_FRAMES);

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] dly_q, dly_d;
  logic       busy_q;
  logic       start_q;
  logic       load_q, load_d;
  logic       hold_q;
  logic       btn_prev_q;

  logic       btn_edge;
  logic       phys_ok;
  logic       running;
  logic       accept;
  logic       delay_tick;

  // A done pulse only counts while an update is outstanding; stray pulses are ignored.
  assign btn_edge   = BTN_RELEASE & ~btn_prev_q;
  assign phys_ok    = PHYS_DONE & busy_q;
  assign running    = (state_q == SERVE) || (state_q == PLAY);
  assign accept     = FRAME_RENDERED & ~SW_PAUSE & running & (~busy_q | PHYS_DONE);
  assign delay_tick = FRAME_RENDERED & ~SW_PAUSE;

  // Next phase, lives, delay count and level-load request.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    dly_d   = dly_q;
    load_d  = 1'b0;
    case (state_q)
      ATTRACT: begin
        if (btn_edge) begin
          state_d = SERVE;
          load_d  = 1'b1;
          lives_d = LIVES_INIT_L;
        end
      end
      SERVE: begin
        if (btn_edge && !SW_PAUSE) state_d = PLAY;
      end
      PLAY: begin
        if (phys_ok) begin
          if (BALL_LOST) begin
            state_d = LOST;
            lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          end else if (BLOCK_STATE == '0) begin
            state_d = CLEARED;
          end
        end
      end
      LOST, CLEARED: begin
        if (dly_q == DELAY_L) begin
          if (state_q == CLEARED) begin
            state_d = SERVE;
            load_d  = 1'b1;
          end else begin
            state_d = (lives_q == 3'd0) ? GAMEOVER : SERVE;
          end
        end else if (delay_tick) begin
          dly_d = dly_q + 8'd1;
        end
      end
      GAMEOVER: begin
        if (btn_edge) state_d = ATTRACT;
      end
      default: state_d = ATTRACT;
    endcase
    // Every phase starts its delay from zero.
    if (state_d != state_q) dly_d = '0;
  end

  // Registered control state and outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ATTRACT;
      lives_q <= LIVES_INIT_L;
      dly_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      load_q  <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      dly_q   <= dly_d;
      busy_q  <= accept | (busy_q & ~PHYS_DONE);
      start_q <= accept;
      load_q  <= load_d;
      hold_q  <= (state_d != PLAY);
    end
  end

  // Button history keeps tracking through reset so a held button yields no edge afterwards.
  always_ff @(posedge CLK) begin
    btn_prev_q <= BTN_RELEASE;
  end

`ifdef GFC_OVERRUN_CNT_EN
  logic [7:0] ovr_q;
  logic       drop;

  assign drop = FRAME_RENDERED & busy_q & ~PHYS_DONE;

  // Saturating dropped-frame count, cleared together with a level load.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ovr_q <= '0;
    end else if (load_d) begin
      ovr_q <= '0;
    end else if (drop && (ovr_q != 8'hFF)) begin
      ovr_q <= ovr_q + 8'd1;
    end
  end

  assign OVERRUN_COUNT = ovr_q;
`else
  assign OVERRUN_COUNT = '0;
`endif

  assign START_UPDATE = start_q;
  assign HOLD_BALL    = hold_q;
  assign LOAD_LEVEL   = load_q;
  assign LIVES        = lives_q;
  assign GAME_STATE   = state_q;

endmodule
